// File: rtl/snes_pad_pkg.sv
// rtl/snes_pad_pkg.sv - SNES pad bit positions, PIA button positions, FSM states and frame decode helpers
package snes_pad_pkg;

  localparam int SNES_B      = 0;
  localparam int SNES_Y      = 1;
  localparam int SNES_SELECT = 2;
  localparam int SNES_START  = 3;
  localparam int SNES_UP     = 4;
  localparam int SNES_DOWN   = 5;
  localparam int SNES_LEFT   = 6;
  localparam int SNES_RIGHT  = 7;
  localparam int SNES_A      = 8;
  localparam int SNES_X      = 9;
  localparam int SNES_L      = 10;
  localparam int SNES_R      = 11;

  localparam int BTN_X     = 0;
  localparam int BTN_B     = 1;
  localparam int BTN_Y     = 2;
  localparam int BTN_A     = 3;
  localparam int BTN_UP    = 4;
  localparam int BTN_DOWN  = 5;
  localparam int BTN_LEFT  = 6;
  localparam int BTN_RIGHT = 7;

  // A real pad always shifts ones out in bits 15:12
  localparam logic [3:0] SIG_ONES = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_LOW,
    ST_HIGH,
    ST_DONE
  } state_t;

  function automatic logic [7:0] map_buttons(input logic [11:0] s);
    logic [7:0] b;
    b            = '1;
    b[BTN_RIGHT] = s[SNES_RIGHT];
    b[BTN_LEFT]  = s[SNES_LEFT];
    b[BTN_DOWN]  = s[SNES_DOWN];
    b[BTN_UP]    = s[SNES_UP];
    b[BTN_A]     = s[SNES_A];
    b[BTN_Y]     = s[SNES_Y];
    b[BTN_B]     = s[SNES_B];
    b[BTN_X]     = s[SNES_X];
    return b;
  endfunction

  function automatic logic [3:0] map_sw(input logic [11:0] s);
    return {s[SNES_R], s[SNES_L], s[SNES_SELECT], s[SNES_START]};
  endfunction

endpackage

// File: rtl/snes_pad_reader_if.sv
// rtl/snes_pad_reader_if.sv - pad-side pins between the reader (master) and the gamepad (slave)
interface snes_pad_reader_if;
  logic pad_data_i;
  logic pad_latch_o;
  logic pad_clk_o;

  modport master (input pad_data_i, output pad_latch_o, output pad_clk_o);
  modport slave  (output pad_data_i, input pad_latch_o, input pad_clk_o);
endinterface

// File: rtl/snes_pad_reader_sync2.sv
// rtl/snes_pad_reader_sync2.sv - two-flop synchronizer for the asynchronous pad data line
module sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  // Resets to the released level so a pre-frame sample reads as idle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      q_o    <= 1'b1;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/snes_pad_reader.sv
// rtl/snes_pad_reader.sv - polls an SNES serial pad and decodes buttons/switches; optional SNES_PAD_DEBOUNCE_EN
module snes_pad_reader
  import snes_pad_pkg::*;
#(
  parameter int HALF_PERIOD = 150,
  parameter int POLL_CYCLES = 416667
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  snes_pad_reader_if.master        pad,
  output logic [7:0]               buttons_o,
  output logic [3:0]               sw_o,
  output logic                     pad_present_o,
  output logic                     valid_o
);

  localparam int TW = $clog2(POLL_CYCLES);
  localparam int CW = $clog2(2 * HALF_PERIOD);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(POLL_CYCLES - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * HALF_PERIOD - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_PERIOD - 1);

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    bit_q;
  logic [15:0]   shreg_q;
  logic          data_s;

`ifdef SNES_PAD_DEBOUNCE_EN
  logic [11:0]   hist_q;
  logic          hist_vld_q;
`endif

  sync2 u_sync2 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (pad.pad_data_i),
    .q_o   (data_s)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_q <= '0;
    end else begin
      timer_q <= (timer_q == TIMER_MAX) ? '0 : timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      bit_q           <= '0;
      shreg_q         <= 16'hFFFF;
      pad.pad_latch_o <= 1'b0;
      pad.pad_clk_o   <= 1'b1;
      buttons_o       <= 8'hFF;
      sw_o            <= 4'hF;
      pad_present_o   <= 1'b0;
      valid_o         <= 1'b0;
`ifdef SNES_PAD_DEBOUNCE_EN
      hist_q          <= '0;
      hist_vld_q      <= 1'b0;
`endif
    end else begin
      valid_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          pad.pad_latch_o <= 1'b0;
          pad.pad_clk_o   <= 1'b1;
          // Polls begin only from IDLE, so a timer wrap mid-frame is ignored
          if (timer_q == '0) begin
            state_q         <= ST_LATCH;
            cnt_q           <= '0;
            pad.pad_latch_o <= 1'b1;
          end
        end
        ST_LATCH: begin
          if (cnt_q == LATCH_LAST) begin
            state_q         <= ST_LOW;
            cnt_q           <= '0;
            bit_q           <= '0;
            pad.pad_latch_o <= 1'b0;
            pad.pad_clk_o   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_LOW: begin
          if (cnt_q == HALF_LAST) begin
            shreg_q[bit_q] <= data_s;
            state_q        <= ST_HIGH;
            cnt_q          <= '0;
            pad.pad_clk_o  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_HIGH: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (bit_q == 4'd15) begin
              state_q <= ST_DONE;
            end else begin
              bit_q         <= bit_q + 1'b1;
              state_q       <= ST_LOW;
              pad.pad_clk_o <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          if (shreg_q[15:12] == SIG_ONES) begin
            pad_present_o <= 1'b1;
`ifdef SNES_PAD_DEBOUNCE_EN
            // Only publish a frame that repeats the previous accepted one
            if (hist_vld_q && (hist_q == shreg_q[11:0])) begin
              buttons_o <= map_buttons(shreg_q[11:0]);
              sw_o      <= map_sw(shreg_q[11:0]);
              valid_o   <= 1'b1;
            end
            hist_q     <= shreg_q[11:0];
            hist_vld_q <= 1'b1;
`else
            buttons_o <= map_buttons(shreg_q[11:0]);
            sw_o      <= map_sw(shreg_q[11:0]);
            valid_o   <= 1'b1;
`endif
          end else begin
            buttons_o     <= 8'hFF;
            sw_o          <= 4'hF;
            pad_present_o <= 1'b0;
            valid_o       <= 1'b1;
`ifdef SNES_PAD_DEBOUNCE_EN
            hist_vld_q    <= 1'b0;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
